// File: rtl/sequenciador_pc_pkg.sv
// Shared encodings for the PC sequencer: branch classes, FSM states, PC-mux selects.
package pc_defs;

  typedef enum logic [2:0] {
    NENHUM = 3'd0,
    BEQ    = 3'd1,
    BNE    = 3'd2,
    BLT    = 3'd3,
    JUMP   = 3'd4,
    JR     = 3'd5
  } tipo_desvio_t;

  typedef enum logic [1:0] {
    EXEC      = 2'd0,
    ESPERA_IO = 2'd1,
    PARADO    = 2'd2,
    ERRO      = 2'd3
  } estado_t;

  localparam logic [1:0] SEL_INC    = 2'd0;
  localparam logic [1:0] SEL_DESVIO = 2'd1;
  localparam logic [1:0] SEL_END    = 2'd2;
  localparam logic [1:0] SEL_REG    = 2'd3;

  // Reserved class codes fall through to sequential execution.
  function automatic logic [1:0] sel_desvio(input logic [2:0] tipo,
                                            input logic       zero,
                                            input logic       negativo);
    logic [1:0] sel;
    sel = SEL_INC;
    case (tipo)
      BEQ:     sel = zero     ? SEL_DESVIO : SEL_INC;
      BNE:     sel = !zero    ? SEL_DESVIO : SEL_INC;
      BLT:     sel = negativo ? SEL_DESVIO : SEL_INC;
      JUMP:    sel = SEL_END;
      JR:      sel = SEL_REG;
      default: sel = SEL_INC;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/sequenciador_pc_detector_borda.sv
// Rising-edge detector for the resume button; history resets to 1 so a button
// held through reset is not seen as a fresh press.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic hist_q, hist_d;

  always_comb begin
    hist_d = sinal;
    borda  = sinal & ~hist_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hist_q <= 1'b1;
    else       hist_q <= hist_d;
  end

endmodule

// File: rtl/sequenciador_pc.sv
// Program-counter owner for the unicycle MIPS core: next-PC select, I/O stall,
// halt/resume and instruction-memory bounds trap.
module sequenciador_pc
  import pc_defs::*;
#(
  parameter int LARGURA    = 32,
  parameter int PC_INICIAL = 0,
  parameter int LIMITE_MEM = 256
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [2:0]         tipo_desvio,
  input  logic               zero,
  input  logic               negativo,
  input  logic               eh_entrada,
  input  logic               eh_saida,
  input  logic               eh_halt,
  input  logic               io_pronto,
  input  logic               continuar,
  input  logic [LARGURA-1:0] novo_PC,
  output logic [LARGURA-1:0] PC,
  output logic [1:0]         mux_PC,
  output logic               habilita_escrita,
  output logic               io_req,
  output logic [1:0]         estado,
  output logic               erro_limite,
  output logic [31:0]        contador_instr
);

  localparam logic [LARGURA-1:0] PC_RESET = LARGURA'(PC_INICIAL);
  localparam logic [LARGURA-1:0] LIMITE   = LARGURA'(LIMITE_MEM);

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] pc_q, pc_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               erro_q, erro_d;
  logic               borda_continuar;
  logic               eh_io;
  logic               fora_limite;

  detector_borda u_detector_borda (
    .clock (clock),
    .reset (reset),
    .sinal (continuar),
    .borda (borda_continuar)
  );

  assign eh_io       = eh_entrada | eh_saida;
  assign fora_limite = (novo_PC >= LIMITE);

  always_comb begin
    estado_d         = estado_q;
    pc_d             = pc_q;
    cnt_d            = cnt_q;
    erro_d           = erro_q;
    mux_PC           = SEL_INC;
    io_req           = 1'b0;
    habilita_escrita = 1'b0;

    case (estado_q)
      EXEC: begin
        mux_PC = sel_desvio(tipo_desvio, zero, negativo);
        if (eh_halt) begin
          // HALT counts as retired but writes nothing.
          estado_d = PARADO;
          cnt_d    = cnt_q + 32'd1;
        end else if (eh_io && !io_pronto) begin
          estado_d = ESPERA_IO;
          io_req   = 1'b1;
        end else if (fora_limite) begin
          estado_d = ERRO;
          erro_d   = 1'b1;
        end else begin
          pc_d             = novo_PC;
          cnt_d            = cnt_q + 32'd1;
          habilita_escrita = 1'b1;
        end
      end
      ESPERA_IO: begin
        mux_PC = sel_desvio(tipo_desvio, zero, negativo);
        io_req = 1'b1;
        if (io_pronto) begin
          if (fora_limite) begin
            estado_d = ERRO;
            erro_d   = 1'b1;
          end else begin
            estado_d         = EXEC;
            pc_d             = novo_PC;
            cnt_d            = cnt_q + 32'd1;
            habilita_escrita = 1'b1;
          end
        end
      end
      PARADO: begin
        // Mux is held at PC+1 here, so resuming steps past the HALT.
        if (borda_continuar) begin
          if (fora_limite) begin
            estado_d = ERRO;
            erro_d   = 1'b1;
          end else begin
            estado_d = EXEC;
            pc_d     = novo_PC;
          end
        end
      end
      default: begin
      end
    endcase

    if (reset) begin
      mux_PC           = SEL_INC;
      io_req           = 1'b0;
      habilita_escrita = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= EXEC;
      pc_q     <= PC_RESET;
      cnt_q    <= 32'd0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      erro_q   <= erro_d;
    end
  end

  assign PC             = pc_q;
  assign estado         = estado_q;
  assign erro_limite    = erro_q;
  assign contador_instr = cnt_q;

endmodule

// File: tb/tb_sequenciador_pc.sv
// Bench for sequenciador_pc: directed scenarios then random traffic against a
// flag-based reference model of the sequencer.
module tb_sequenciador_pc;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  tipo_desvio;
  logic        zero, negativo, eh_entrada, eh_saida, eh_halt, io_pronto, continuar;
  logic [31:0] novo_PC;
  logic [31:0] PC;
  logic [1:0]  mux_PC;
  logic        habilita_escrita, io_req;
  logic [1:0]  estado;
  logic        erro_limite;
  logic [31:0] contador_instr;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: plain flags instead of a state machine.
  logic [31:0] m_pc, m_cnt;
  bit          m_err, m_halt, m_wait, m_prev_cont;

  sequenciador_pc #(.LARGURA(32), .PC_INICIAL(0), .LIMITE_MEM(256)) dut (
    .clock            (clock),
    .reset            (reset),
    .tipo_desvio      (tipo_desvio),
    .zero             (zero),
    .negativo         (negativo),
    .eh_entrada       (eh_entrada),
    .eh_saida         (eh_saida),
    .eh_halt          (eh_halt),
    .io_pronto        (io_pronto),
    .continuar        (continuar),
    .novo_PC          (novo_PC),
    .PC               (PC),
    .mux_PC           (mux_PC),
    .habilita_escrita (habilita_escrita),
    .io_req           (io_req),
    .estado           (estado),
    .erro_limite      (erro_limite),
    .contador_instr   (contador_instr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_estado();
    if (m_err)  return 32'd3;
    if (m_halt) return 32'd2;
    if (m_wait) return 32'd1;
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_mux();
    if (m_err || m_halt) return 32'd0;
    case (tipo_desvio)
      3'd1:    return zero     ? 32'd1 : 32'd0;
      3'd2:    return !zero    ? 32'd1 : 32'd0;
      3'd3:    return negativo ? 32'd1 : 32'd0;
      3'd4:    return 32'd2;
      3'd5:    return 32'd3;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit io_blocked();
    return (eh_entrada || eh_saida) && !io_pronto;
  endfunction

  function automatic logic [31:0] exp_ioreq();
    if (m_err || m_halt) return 32'd0;
    if (m_wait) return 32'd1;
    return (!eh_halt && io_blocked()) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_we();
    bit ok;
    ok = (novo_PC < 32'd256);
    if (m_err || m_halt) return 32'd0;
    if (m_wait) return (io_pronto && ok) ? 32'd1 : 32'd0;
    return (!eh_halt && !io_blocked() && ok) ? 32'd1 : 32'd0;
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_cnt = 32'd0;
    m_err = 1'b0; m_halt = 1'b0; m_wait = 1'b0; m_prev_cont = 1'b1;
  endtask

  task automatic model_edge();
    bit press, ok;
    press       = continuar && !m_prev_cont;
    m_prev_cont = continuar;
    ok          = (novo_PC < 32'd256);
    if (m_err) begin
    end else if (m_halt) begin
      if (press) begin
        m_halt = 1'b0;
        if (ok) m_pc = novo_PC; else m_err = 1'b1;
      end
    end else if (m_wait) begin
      if (io_pronto) begin
        m_wait = 1'b0;
        if (ok) begin m_pc = novo_PC; m_cnt++; end else m_err = 1'b1;
      end
    end else if (eh_halt) begin
      m_halt = 1'b1; m_cnt++;
    end else if (io_blocked()) begin
      m_wait = 1'b1;
    end else if (!ok) begin
      m_err = 1'b1;
    end else begin
      m_pc = novo_PC; m_cnt++;
    end
  endtask

  task automatic chk_regs();
    chk("PC", PC, m_pc);
    chk("estado", 32'(estado), exp_estado());
    chk("contador_instr", contador_instr, m_cnt);
    chk("erro_limite", 32'(erro_limite), 32'(m_err));
  endtask

  task automatic drv(input logic [2:0] t, input logic z, input logic n, input logic ent,
                     input logic sai, input logic hlt, input logic pr, input logic cont,
                     input logic [31:0] novo);
    tipo_desvio = t; zero = z; negativo = n; eh_entrada = ent; eh_saida = sai;
    eh_halt = hlt; io_pronto = pr; continuar = cont; novo_PC = novo;
  endtask

  task automatic step();
    #1;
    chk("mux_PC", 32'(mux_PC), exp_mux());
    chk("io_req", 32'(io_req), exp_ioreq());
    chk("habilita_escrita", 32'(habilita_escrita), exp_we());
    @(posedge clock);
    model_edge();
    #1;
    chk_regs();
  endtask

  // Reset asserted mid-cycle; state must clear without a clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk_regs();
    chk("reset_mux_PC", 32'(mux_PC), 32'd0);
    chk("reset_io_req", 32'(io_req), 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drv(3'd0, 0, 0, 0, 0, 0, 0, 0, 32'd1);
    #12;
    model_reset();
    chk_regs();
    chk("reset_mux_PC", 32'(mux_PC), 32'd0);
    chk("reset_io_req", 32'(io_req), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Sequential execution
    for (int i = 0; i < 3; i++) begin
      drv(3'd0, 0, 0, 0, 0, 0, 0, 0, m_pc + 32'd1);
      step();
    end
    chk("pc_after_3", PC, 32'd3);
    chk("count_after_3", contador_instr, 32'd3);

    // Branch selects
    drv(3'd1, 1, 0, 0, 0, 0, 0, 0, m_pc + 32'd5); step();
    drv(3'd1, 0, 0, 0, 0, 0, 0, 0, m_pc + 32'd1); step();
    drv(3'd2, 0, 1, 0, 0, 0, 0, 0, m_pc + 32'd2); step();
    drv(3'd3, 1, 1, 0, 0, 0, 0, 0, m_pc + 32'd3); step();
    drv(3'd5, 0, 0, 0, 0, 0, 0, 0, 32'd20);       step();
    drv(3'd4, 0, 0, 0, 0, 0, 0, 0, 32'h40);       step();
    chk("pc_after_jump", PC, 32'h40);

    // I/O stall for 4 cycles then completion
    for (int i = 0; i < 4; i++) begin
      drv(3'd0, 0, 0, 1, 0, 0, 0, 0, m_pc + 32'd1);
      step();
    end
    chk("io_wait_pc", PC, 32'h40);
    drv(3'd0, 0, 0, 1, 0, 0, 1, 0, m_pc + 32'd1); step();
    chk("io_done_pc", PC, 32'h41);
    // I/O with peripheral already ready retires at once
    drv(3'd0, 0, 0, 0, 1, 0, 1, 0, m_pc + 32'd1); step();

    // Halt at PC=5, resume once with a held button
    drv(3'd4, 0, 0, 0, 0, 0, 0, 0, 32'd5); step();
    drv(3'd0, 0, 0, 0, 0, 1, 0, 0, 32'd6); step();
    chk("halt_pc", PC, 32'd5);
    drv(3'd0, 0, 0, 0, 0, 0, 0, 1, 32'd6); step();
    chk("resume_pc", PC, 32'd6);
    drv(3'd0, 0, 0, 0, 0, 1, 0, 1, 32'd7); step();
    for (int i = 0; i < 8; i++) begin
      drv(3'd0, 0, 0, 0, 0, 0, 0, 1, m_pc + 32'd1);
      step();
    end
    chk("held_button_estado", 32'(estado), 32'd2);
    chk("held_button_pc", PC, 32'd6);
    do_reset();
    chk("reset_mid_halt_pc", PC, 32'd0);

    // Bounds trap is terminal
    drv(3'd4, 0, 0, 0, 0, 0, 0, 0, 32'd256); step();
    chk("trap_flag", 32'(erro_limite), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drv(3'd0, 0, 0, 1, 0, 0, 1, (i % 2) == 0, 32'd3);
      step();
    end
    chk("trap_sticky_estado", 32'(estado), 32'd3);
    do_reset();

    // Halt beats I/O
    drv(3'd0, 0, 0, 0, 1, 1, 0, 0, 32'd1); step();
    chk("halt_over_io_estado", 32'(estado), 32'd2);
    drv(3'd0, 0, 0, 0, 0, 0, 0, 1, 32'd1); step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [31:0] novo;
      if ($urandom_range(0, 59) == 0 || (m_err && $urandom_range(0, 7) == 0))
        do_reset();
      r = int'($urandom_range(0, 39));
      if (r == 0)       novo = 32'($urandom_range(256, 1000));
      else if (r == 1)  novo = $urandom;
      else if (r < 20)  novo = m_pc + 32'd1;
      else              novo = 32'($urandom_range(0, 255));
      r = int'($urandom_range(0, 11));
      drv(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
          r == 0, r == 1, $urandom_range(0, 11) == 0, 1'($urandom),
          ($urandom_range(0, 3) == 0) ? !continuar : continuar, novo);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
